// File: rtl/serial_universal_adder_pkg.sv
// Shared constants for the bit-serial universal adder.
// FSM encodings, default width and counter sizing helper.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Bits needed to count 0..w-1 (at least one).
    function automatic int clog2(input int w);
        int n;
        n = 1;
        while ((1 << n) < w) n++;
        return n;
    endfunction

endpackage

// File: rtl/serial_universal_adder_full_adder.sv
// One-bit full adder used as the per-bit serial datapath.
// Ports: a, b, cin -> s (sum), cout (majority carry).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_universal_adder.sv
// Bit-serial adder: {carry,S} = A + B + op, LSB first, WIDTH cycles.
// Ports: clk, rst, start, A, B, op in; S, carry, busy, done out.
module serial_universal_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             op,
    output logic [WIDTH-1:0] S,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             sum_bit;
    logic             cout_bit;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .s    (sum_bit),
        .cout (cout_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
        end else begin
            unique case (1'b1)
                (state_q == IDLE): begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        c_q     <= op;
                        cnt_q   <= '0;
                        s_q     <= '0;
                        state_q <= SHIFT;
                    end
                end
                (state_q == SHIFT): begin
                    // Sum bits enter at the MSB so S ends LSB-aligned.
                    s_q   <= {sum_bit, s_q[WIDTH-1:1]};
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    c_q   <= cout_bit;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) state_q <= DONE;
                end
                (state_q == DONE): begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign S     = s_q;
    assign carry = c_q;
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_universal_adder.sv
// Self-checking bench for serial_universal_adder (WIDTH=4).
// Directed vectors, handshake scenarios and a random sweep.
module tb_serial_universal_adder;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         op;
    logic [W-1:0] S;
    logic         carry;
    logic         busy;
    logic         done;

    int errors;
    int checks;
    int cyc;

    serial_universal_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .op    (op),
        .S     (S),
        .carry (carry),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap cyc=%0d busy=%b done=%b want not both",
                         cyc, busy, done);
            end
        end
    end

    // Starts one op from IDLE, waits for done, checks result and latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic o, input logic [W-1:0] es,
                          input logic ec, input string nm);
        int n;
        bit seen;
        @(negedge clk);
        A = a; B = b; op = o; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout no done within %0d edges", nm, n);
        end else begin
            checks++;
            if (n !== W) begin
                errors++;
                $display("FAIL %s_latency got=%0d want=%0d", nm, n, W);
            end
            checks++;
            if ({carry, S} !== {ec, es}) begin
                errors++;
                $display("FAIL %s_result got c=%b S=%0d want c=%b S=%0d",
                         nm, carry, S, ec, es);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        checks++;
        if ({S, carry, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_state got S=%0d c=%b busy=%b done=%b want all 0",
                     S, carry, busy, done);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        A = 4'd9; B = 4'd4; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({S, carry, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid_op got S=%0d c=%b busy=%b done=%b want all 0",
                     S, carry, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(4'd9, 4'd4, 1'b0, 4'd13, 1'b0, "after_reset");
    endtask

    task automatic test_directed;
        run_op(4'd5,  4'd4, 1'b0, 4'd9,  1'b0, "inv_9m4");
        run_op(4'd4,  4'd4, 1'b1, 4'd9,  1'b0, "inv_9m4m1");
        run_op(4'd12, 4'd9, 1'b0, 4'd5,  1'b1, "inv_5m9");
        run_op(4'd0,  4'd7, 1'b1, 4'd8,  1'b0, "inv_8m7m1");
        run_op(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, "max");
        run_op(4'd0,  4'd0, 1'b0, 4'd0,  1'b0, "zero");
    endtask

    task automatic test_ignore_start;
        int pulses;
        @(negedge clk);
        A = 4'd3; B = 4'd5; op = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0;
        @(negedge clk);
        A = 4'd15; B = 4'd15; op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    checks++;
                    if ({carry, S} !== 5'd8) begin
                        errors++;
                        $display("FAIL ignore_result got c=%b S=%0d want c=0 S=8",
                                 carry, S);
                    end
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_pulses got=%0d want=1", pulses);
        end
        checks++;
        if ({carry, S} !== 5'd8 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_hold got c=%b S=%0d busy=%b want c=0 S=8 busy=0",
                     carry, S, busy);
        end
    endtask

    task automatic test_back_to_back;
        int t[3];
        int k;
        int n;
        @(negedge clk);
        A = 4'd6; B = 4'd7; op = 1'b1; start = 1'b1;
        k = 0;
        n = 0;
        while (k < 3 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                t[k] = cyc;
                checks++;
                if ({carry, S} !== 5'd14) begin
                    errors++;
                    $display("FAIL b2b_result%0d got c=%b S=%0d want c=0 S=14",
                             k, carry, S);
                end
                k++;
            end
        end
        start = 1'b0;
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d want=3", k);
        end else begin
            checks++;
            if (t[1] - t[0] !== 6 || t[2] - t[1] !== 6) begin
                errors++;
                $display("FAIL b2b_spacing got=%0d,%0d want=6,6",
                         t[1] - t[0], t[2] - t[1]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         o;
        logic [W:0]   sum;
        for (int i = 0; i < 500; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            o = 1'($urandom);
            sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, o};
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(a, b, o, sum[W-1:0], sum[W], "random");
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        start  = 1'b0;
        A      = '0;
        B      = '0;
        op     = 1'b0;
        test_reset;
        test_reset_mid_op;
        test_directed;
        test_ignore_start;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
